// File: rtl/alu_cmd_issue_if.sv
// Command and result handshake bundle between a producer/consumer and alu_cmd_issue.
interface alu_cmd_issue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_func;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_flags;
  logic [3:0]  res_func;

  modport master (output cmd_valid, cmd_a, cmd_b, cmd_func, res_ready,
                  input  cmd_ready, res_valid, res_data, res_flags, res_func);
  modport slave  (input  cmd_valid, cmd_a, cmd_b, cmd_func, res_ready,
                  output cmd_ready, res_valid, res_data, res_flags, res_func);
endinterface

// File: rtl/alu_cmd_issue.sv
// Issue stage for a clocked ALU: command FIFO, one-at-a-time issue, wait for
// the ALU's registered latency, then hold the captured result until accepted.
module alu_cmd_issue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_issue_if.slave         bus,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [3:0]             alu_func,
  input  logic [15:0]            alu_out,
  input  logic [3:0]             alu_flags,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  func;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [3:0]    alu_func_q, alu_func_d, res_flags_q, res_flags_d, res_func_q, res_func_d;
  logic          res_valid_q, res_valid_d;
  logic          push, pop;

  assign head = mem_q[rptr_q];
  assign push = bus.cmd_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_func_d  = res_func_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (level_q != '0) begin
        pop        = 1'b1;
        alu_a_d    = head.a;
        alu_b_d    = head.b;
        alu_func_d = head.func;
        res_func_d = head.func;
        cnt_d      = CW'(ALU_LAT);
        state_d    = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        res_data_d  = alu_out;
        res_flags_d = alu_flags;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      HOLD: if (bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Storage carries no reset: occupancy is tracked solely by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{a: bus.cmd_a, b: bus.cmd_b, func: bus.cmd_func};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      ready_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_func_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      // Ready is a function of the next level only, so a pop never enables a push at full.
      ready_q     <= (level_d < LW'(DEPTH));
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_func_q  <= res_func_d;
      res_valid_q <= res_valid_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_func  = res_func_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_func      = alu_func_q;
  assign fifo_level    = level_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a stand-in ALU and an ordered-result model.
module tb_alu_cmd_issue;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_func, alu_flags;
  logic [2:0]  fifo_level;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  int          nres = 0;
  logic [15:0] last_data = '0;

  always #5 clk = ~clk;

  alu_cmd_issue_if bus();

  alu_cmd_issue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .fifo_level(fifo_level), .busy(busy)
  );

  // Stand-in ALU: {flags, result}
  function automatic logic [19:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] f);
    logic [15:0] r;
    logic [3:0]  fl;
    case (f)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[3:0];
      4'd6: r = a >> b[3:0];
      4'd7: r = {15'd0, a < b};
      default: r = ~a;
    endcase
    fl = {f <= 4'd1, (f >= 4'd2 && f <= 4'd4), r == 16'd0, (f == 4'd5 || f == 4'd6)};
    return {fl, r};
  endfunction

  // One registered stage, matching ALU_LAT=1.
  always @(posedge clk) {alu_flags, alu_out} <= alu_fn(alu_a, alu_b, alu_func);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
  } ent_t;
  ent_t exp_q[$];
  ent_t mon_e;
  logic [19:0] mon_m;

  // Model: accepted commands come back in order, each result = alu_fn of its command.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          chk("res_spurious", bus.res_valid, 0);
        end else begin
          mon_e = exp_q[0];
          mon_m = alu_fn(mon_e.a, mon_e.b, mon_e.f);
          chk("res_data", bus.res_data, mon_m[15:0]);
          chk("res_flags", bus.res_flags, mon_m[19:16]);
          chk("res_func", bus.res_func, mon_e.f);
          if (bus.res_ready) begin
            void'(exp_q.pop_front());
            nres++;
            last_data = bus.res_data;
          end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back('{a: bus.cmd_a, b: bus.cmd_b, f: bus.cmd_func});
    end
  end

  // Called and returns at posedge+#1; returns after the accepting edge.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int  n = 0;
    bit  acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_func = f;
    do begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    bus.cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", bus.cmd_ready, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.res_valid || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_level", fifo_level, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("wait_valid_timeout", bus.res_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_func = '0;
    bus.res_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cmd_ready", bus.cmd_ready, 1);

    // Latency with ALU_LAT=1
    push(16'd5, 16'd5, 4'd0);
    @(posedge clk); #1;
    chk("lat_alu_a", alu_a, 16'd5);
    chk("lat_alu_b", alu_b, 16'd5);
    chk("lat_valid_n2", bus.res_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_n2b", bus.res_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_n3", bus.res_valid, 1);
    chk("lat_data", bus.res_data, 16'd10);
    chk("lat_flags", bus.res_flags, 4'b1000);
    wait_drain();

    // Ordering: 16 back-to-back commands
    base = nres;
    for (int k = 0; k < 16; k++) push(16'(k), 16'd5, 4'(k));
    wait_drain();
    chk("ord_count", nres - base, 16);
    chk("ord_last", last_data, 16'hFFF0);

    // Full / backpressure
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_b = 16'd3;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.cmd_a = 16'(100 + acc);
      bus.cmd_func = 4'(acc);
      @(negedge clk);
      if (bus.cmd_ready) acc++;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("full_accepted", acc, 5);
    chk("full_ready", bus.cmd_ready, 0);
    chk("full_level", fifo_level, 4);
    chk("full_valid", bus.res_valid, 1);
    chk("full_func", bus.res_func, 0);
    chk("full_data", bus.res_data, 16'd103);

    // Drain with a one-cycle res_ready pulse every 8 cycles
    base = nres;
    for (int p = 0; p < 6; p++) begin
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      if (p == 0) chk("drain_ready_back", bus.cmd_ready, 1);
      repeat (4) begin @(posedge clk); #1; end
    end
    chk("drain_count", nres - base, 5);
    chk("drain_level0", fifo_level, 0);
    bus.res_ready = 1'b1;
    wait_drain();

    // Simultaneous push/pop at level 2, across pointer wrap
    bus.res_ready = 1'b0;
    push(16'd200, 16'd1, 4'd2);
    push(16'd201, 16'd1, 4'd3);
    push(16'd202, 16'd1, 4'd4);
    wait_valid();
    chk("sim_pre_level", fifo_level, 2);
    for (int i = 0; i < 6; i++) begin
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 16'(300 + i);
      bus.cmd_b = 16'd2;
      bus.cmd_func = 4'(5 + i);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      chk("sim_level", fifo_level, 2);
      chk("sim_issue_a", alu_a, (i < 2) ? 201 + i : 298 + i);
      chk("sim_issue_f", alu_func, 3 + i);
      wait_valid();
    end
    bus.res_ready = 1'b1;
    wait_drain();

    // Asynchronous reset mid-WAIT
    push(16'd7, 16'd1, 4'd0);
    push(16'd8, 16'd1, 4'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_res_func", bus.res_func, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("arst_no_valid", bus.res_valid, 0);
    end
    chk("arst_ready_back", bus.cmd_ready, 1);
    push(16'd9, 16'd9, 4'd0);
    wait_valid();
    chk("arst_restart", bus.res_data, 16'd18);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
